// File: rtl/mem_write_monitor_pkg.sv
// Shared types for the data-memory write monitor: FSM states, fail codes, width helper.
// Pure declarations; no logic, no latency.
package mem_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_PASS  = 2'd2,
      ST_FAIL  = 2'd3
   } state_t;

   localparam logic [1:0] FC_NONE     = 2'd0;
   localparam logic [1:0] FC_MISMATCH = 2'd1;
   localparam logic [1:0] FC_TIMEOUT  = 2'd2;
   localparam logic [1:0] FC_CONFIG   = 2'd3;

   // Never returns 0 so that a one-entry table still gets a real index bit.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/mem_write_monitor_if.sv
// Processor data-memory write port as seen by the monitor (MemWrite/DataAdr/WriteData).
// Observation only; the monitor never pushes back on the processor.
interface mem_write_monitor_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              MemWrite;
   logic [ADDR_W-1:0] DataAdr;
   logic [DATA_W-1:0] WriteData;

   modport master (output MemWrite, output DataAdr, output WriteData);
   modport slave  (input  MemWrite, input  DataAdr, input  WriteData);
endinterface

// File: rtl/mem_write_monitor_ign_cam.sv
// Ignore-address list: IGN_N registered address/valid pairs with a parallel compare.
// Entry written on the edge after i_we; o_hit is combinational from the stored entries.
module mem_mon_ign_cam #(
   parameter int ADDR_W = 32,
   parameter int IGN_N  = 2,
   parameter int IDX_W  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [ADDR_W-1:0] i_cmp_addr,
   output logic              o_hit
);

   logic [ADDR_W-1:0] r_addr [IGN_N];
   logic [IGN_N-1:0]  r_vld;

   // Out-of-range indices match no entry and are silently dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vld <= '0;
         for (int i = 0; i < IGN_N; i++) r_addr[i] <= '0;
      end else begin
         for (int i = 0; i < IGN_N; i++) begin
            if (i_we && (int'(i_idx) == i)) begin
               r_addr[i] <= i_addr;
               r_vld[i]  <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      o_hit = 1'b0;
      for (int i = 0; i < IGN_N; i++) begin
         if (r_vld[i] && (r_addr[i] == i_cmp_addr)) o_hit = 1'b1;
      end
   end

endmodule

// File: rtl/mem_write_monitor.sv
// Pass/fail monitor for the data-memory write port: ordered expected writes, ignore list, timeout.
// Result registered on the edge that samples the deciding write (visible next cycle); no backpressure.
module mem_write_monitor
   import mem_mon_pkg::*;
#(
   parameter  int ADDR_W  = 32,
   parameter  int DATA_W  = 32,
   parameter  int DEPTH   = 4,
   parameter  int IGN_N   = 2,
   parameter  int TIMEOUT = 4096,
   parameter  int CYC_W   = 16,
   localparam int LEN_W   = clog2(DEPTH + 1),
   localparam int PTR_W   = clog2(DEPTH),
   localparam int IDX_W   = clog2((DEPTH > IGN_N) ? DEPTH : IGN_N)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  exp_len,
   input  logic              cfg_we,
   input  logic              cfg_sel,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   mem_write_monitor_if.slave bus,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [1:0]        fail_code,
   output logic [PTR_W-1:0]  fail_idx,
   output logic [LEN_W-1:0]  match_count,
   output logic [CYC_W-1:0]  cycle_count
);

   state_t            r_state, w_state_nxt;
   logic [LEN_W-1:0]  r_len, w_len_nxt;
   logic [LEN_W-1:0]  r_match, w_match_nxt;
   logic [PTR_W-1:0]  r_ptr, w_ptr_nxt;
   logic [PTR_W-1:0]  r_fidx, w_fidx_nxt;
   logic [CYC_W-1:0]  r_cyc, w_cyc_nxt;
   logic              r_done, w_done_nxt;
   logic              r_pass, w_pass_nxt;
   logic              r_fail, w_fail_nxt;
   logic [1:0]        r_fcode, w_fcode_nxt;

   logic [ADDR_W-1:0] r_exp_addr [DEPTH];
   logic [DATA_W-1:0] r_exp_data [DEPTH];

   logic              w_cfg_ok;
   logic              w_ign_hit;
   logic              w_exp_match;
   logic              w_last;
   logic              w_tmo;

   assign w_cfg_ok = cfg_we && (r_state != ST_ARMED);

   mem_mon_ign_cam #(
      .ADDR_W (ADDR_W),
      .IGN_N  (IGN_N),
      .IDX_W  (IDX_W)
   ) u_ign (
      .clk        (clk),
      .reset      (reset),
      .i_we       (w_cfg_ok && cfg_sel),
      .i_idx      (cfg_idx),
      .i_addr     (cfg_addr),
      .i_cmp_addr (bus.DataAdr),
      .o_hit      (w_ign_hit)
   );

   // Table contents are don't-care after reset, so no reset branch here.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (w_cfg_ok && !cfg_sel && (int'(cfg_idx) == i)) begin
            r_exp_addr[i] <= cfg_addr;
            r_exp_data[i] <= cfg_data;
         end
      end
   end

   assign w_exp_match = bus.MemWrite && (bus.DataAdr == r_exp_addr[r_ptr])
                        && (bus.WriteData == r_exp_data[r_ptr]);
   assign w_last      = ((LEN_W'(r_ptr) + LEN_W'(1)) == r_len);
   assign w_tmo       = (TIMEOUT != 0) && (r_cyc == CYC_W'(TIMEOUT - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_len_nxt   = r_len;
      w_match_nxt = r_match;
      w_ptr_nxt   = r_ptr;
      w_fidx_nxt  = r_fidx;
      w_cyc_nxt   = r_cyc;
      w_done_nxt  = r_done;
      w_pass_nxt  = r_pass;
      w_fail_nxt  = r_fail;
      w_fcode_nxt = r_fcode;

      case (r_state)
         ST_ARMED: begin
            if (r_cyc != '1) w_cyc_nxt = r_cyc + CYC_W'(1);
            // Written so that an X on MemWrite falls through to the mismatch branch.
            if (w_exp_match) begin
               w_ptr_nxt   = r_ptr + PTR_W'(1);
               w_match_nxt = r_match + LEN_W'(1);
               if (w_last) begin
                  w_state_nxt = ST_PASS;
                  w_done_nxt  = 1'b1;
                  w_pass_nxt  = 1'b1;
               end
            end else if (bus.MemWrite && w_ign_hit) begin
            end else if (!bus.MemWrite) begin
            end else begin
               w_state_nxt = ST_FAIL;
               w_done_nxt  = 1'b1;
               w_fail_nxt  = 1'b1;
               w_fcode_nxt = FC_MISMATCH;
               w_fidx_nxt  = r_ptr;
            end
            if ((w_state_nxt == ST_ARMED) && w_tmo) begin
               w_state_nxt = ST_FAIL;
               w_done_nxt  = 1'b1;
               w_fail_nxt  = 1'b1;
               w_fcode_nxt = FC_TIMEOUT;
               w_fidx_nxt  = r_ptr;
            end
         end
         default: begin
            if (start) begin
               w_ptr_nxt   = '0;
               w_match_nxt = '0;
               w_cyc_nxt   = '0;
               w_pass_nxt  = 1'b0;
               if ((exp_len == '0) || (int'(exp_len) > DEPTH)) begin
                  w_state_nxt = ST_FAIL;
                  w_done_nxt  = 1'b1;
                  w_fail_nxt  = 1'b1;
                  w_fcode_nxt = FC_CONFIG;
                  w_fidx_nxt  = '0;
               end else begin
                  w_state_nxt = ST_ARMED;
                  w_len_nxt   = exp_len;
                  w_done_nxt  = 1'b0;
                  w_fail_nxt  = 1'b0;
                  w_fcode_nxt = FC_NONE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_len   <= '0;
         r_match <= '0;
         r_ptr   <= '0;
         r_fidx  <= '0;
         r_cyc   <= '0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_fail  <= 1'b0;
         r_fcode <= FC_NONE;
      end else begin
         r_state <= w_state_nxt;
         r_len   <= w_len_nxt;
         r_match <= w_match_nxt;
         r_ptr   <= w_ptr_nxt;
         r_fidx  <= w_fidx_nxt;
         r_cyc   <= w_cyc_nxt;
         r_done  <= w_done_nxt;
         r_pass  <= w_pass_nxt;
         r_fail  <= w_fail_nxt;
         r_fcode <= w_fcode_nxt;
      end
   end

   assign done        = r_done;
   assign pass        = r_pass;
   assign fail        = r_fail;
   assign fail_code   = r_fcode;
   assign fail_idx    = r_fidx;
   assign match_count = r_match;
   assign cycle_count = r_cyc;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor; expected results queued at stimulus time, popped at done.
module tb_mem_write_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  exp_len;
   logic        cfg_we;
   logic        cfg_sel;
   logic [1:0]  cfg_idx;
   logic [31:0] cfg_addr;
   logic [31:0] cfg_data;
   logic        done;
   logic        pass;
   logic        fail;
   logic [1:0]  fail_code;
   logic [1:0]  fail_idx;
   logic [2:0]  match_count;
   logic [15:0] cycle_count;

   typedef struct {
      logic       pass;
      logic [1:0] code;
      logic [1:0] idx;
      logic [2:0] mcnt;
   } res_t;

   res_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   n;

   always #5 clk = ~clk;

   mem_write_monitor_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_write_monitor #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .DEPTH   (4),
      .IGN_N   (2),
      .TIMEOUT (16),
      .CYC_W   (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .exp_len     (exp_len),
      .cfg_we      (cfg_we),
      .cfg_sel     (cfg_sel),
      .cfg_idx     (cfg_idx),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .bus         (bus.slave),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .fail_code   (fail_code),
      .fail_idx    (fail_idx),
      .match_count (match_count),
      .cycle_count (cycle_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic cfg_exp(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = idx; cfg_addr = a; cfg_data = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic cfg_ign(input logic [1:0] idx, input logic [31:0] a);
      cfg_we = 1'b1; cfg_sel = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = '0;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic arm(input logic [2:0] len);
      exp_len = len; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.MemWrite = 1'b1; bus.DataAdr = a; bus.WriteData = d;
      step();
      bus.MemWrite = 1'b0;
   endtask

   task automatic expect_res(input logic p, input logic [1:0] c, input logic [1:0] i,
                             input logic [2:0] m);
      res_t e;
      e.pass = p; e.code = c; e.idx = i; e.mcnt = m;
      sb.push_back(e);
   endtask

   task automatic wait_done(input string tag, output int cyc);
      res_t e;
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         step();
         cyc++;
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_sb"}, sb.size(), 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_pass"}, pass, e.pass);
         chk({tag, "_fail"}, fail, !e.pass);
         chk({tag, "_code"}, fail_code, e.code);
         chk({tag, "_mcnt"}, match_count, e.mcnt);
         if (!e.pass) chk({tag, "_idx"}, fail_idx, e.idx);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_fail"}, fail, 0);
      chk({tag, "_code"}, fail_code, 0);
      chk({tag, "_mcnt"}, match_count, 0);
      chk({tag, "_cyc"}, cycle_count, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; exp_len = '0;
      cfg_we = 1'b0; cfg_sel = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
      bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;
      #2;
      chk_zero("reset");
      step(); step();
      reset = 1'b0;

      // Legacy single-write program with two ignored writes first.
      cfg_ign(2'd0, 32'd96);
      cfg_exp(2'd0, 32'd100, 32'd7);
      arm(3'd1);
      chk("armed_done", done, 0);
      wr(32'd96, 32'h11);
      wr(32'd96, 32'h22);
      wr(32'd100, 32'd7);
      expect_res(1'b1, 2'd0, 2'd0, 3'd1);
      wait_done("legacy", n);
      chk("legacy_lat", n, 0);
      chk("legacy_cyc", cycle_count, 3);

      arm(3'd1);
      wr(32'd100, 32'd8);
      expect_res(1'b0, 2'd1, 2'd0, 3'd0);
      wait_done("wrong_data", n);

      arm(3'd1);
      wr(32'd104, 32'd7);
      expect_res(1'b0, 2'd1, 2'd0, 3'd0);
      wait_done("wrong_addr", n);

      // Ordered sequence, then the same with entries 2 and 3 swapped.
      cfg_exp(2'd0, 32'd100, 32'd1);
      cfg_exp(2'd1, 32'd104, 32'd2);
      cfg_exp(2'd2, 32'd108, 32'd3);
      arm(3'd3);
      wr(32'd100, 32'd1);
      wr(32'd96, 32'd5);
      wr(32'd104, 32'd2);
      idle(1);
      wr(32'd96, 32'd6);
      wr(32'd108, 32'd3);
      expect_res(1'b1, 2'd0, 2'd0, 3'd3);
      wait_done("ordered", n);

      arm(3'd3);
      wr(32'd100, 32'd1);
      wr(32'd108, 32'd3);
      expect_res(1'b0, 2'd1, 2'd1, 3'd1);
      wait_done("swapped", n);

      // Timeout fires on the 16th ARMED edge.
      arm(3'd3);
      expect_res(1'b0, 2'd2, 2'd0, 3'd0);
      wait_done("timeout", n);
      chk("timeout_edges", n, 16);
      chk("timeout_cyc", cycle_count, 16);

      // Final match on the timeout edge: pass wins.
      arm(3'd1);
      idle(15);
      chk("pre_tmo_done", done, 0);
      chk("pre_tmo_cyc", cycle_count, 15);
      wr(32'd100, 32'd1);
      expect_res(1'b1, 2'd0, 2'd0, 3'd1);
      wait_done("tmo_edge_pass", n);

      arm(3'd0);
      expect_res(1'b0, 2'd3, 2'd0, 3'd0);
      wait_done("len0", n);
      chk("len0_lat", n, 0);

      arm(3'd5);
      expect_res(1'b0, 2'd3, 2'd0, 3'd0);
      wait_done("len5", n);

      // Config write while ARMED must not disturb the table.
      arm(3'd1);
      cfg_exp(2'd0, 32'd200, 32'd9);
      wr(32'd100, 32'd1);
      expect_res(1'b1, 2'd0, 2'd0, 3'd1);
      wait_done("cfg_armed", n);

      // Ignore index beyond IGN_N is dropped, not aliased.
      cfg_ign(2'd2, 32'd300);
      arm(3'd1);
      wr(32'd300, 32'd0);
      expect_res(1'b0, 2'd1, 2'd0, 3'd0);
      wait_done("ign_oob", n);

      // Asynchronous reset in the middle of an ARMED run.
      cfg_exp(2'd0, 32'd100, 32'd1);
      cfg_exp(2'd1, 32'd104, 32'd2);
      arm(3'd2);
      wr(32'd100, 32'd1);
      idle(1);
      chk("pre_rst_mcnt", match_count, 1);
      chk("pre_rst_cyc", cycle_count, 2);
      #3 reset = 1'b1;
      #1;
      chk_zero("mid_rst");
      step();
      reset = 1'b0;

      cfg_exp(2'd0, 32'd100, 32'd1);
      arm(3'd1);
      wr(32'd96, 32'd0);
      expect_res(1'b0, 2'd1, 2'd0, 3'd0);
      wait_done("post_rst_ign", n);

      cfg_ign(2'd0, 32'd96);
      arm(3'd1);
      wr(32'd96, 32'd0);
      wr(32'd100, 32'd1);
      expect_res(1'b1, 2'd0, 2'd0, 3'd1);
      wait_done("post_rst_pass", n);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
